// File: rtl/accum_compare_seq.sv
// accum_compare_seq
// Sequencing controller for the accumulate-and-compare datapath. A start
// request clears the accumulator, adds n_ops operands from consecutive RAM
// addresses, lets the comparator settle, and reports small/large with a
// one-cycle done pulse. All datapath strobes are Moore-decoded from state.
// rd_addr is a zero-extension of the CNT_W-bit index, so ADDR_W >= CNT_W.

module accum_compare_seq #(
    parameter int CNT_W  = 4,
    parameter int ADDR_W = 4
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              start,
    input  logic [CNT_W-1:0]  n_ops,
    input  logic              x,
    output logic              clr,
    output logic              we,
    output logic              s,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              busy,
    output logic              done,
    output logic              result
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        ADD   = 3'd2,
        COMP  = 3'd3,
        SMALL = 3'd4,
        LARGE = 3'd5
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] idx, idx_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             result_q, result_next;

    // State, operand index, captured count and result register; reset aborts any run
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            idx      <= '0;
            cnt      <= '0;
            result_q <= 1'b0;
        end else begin
            state    <= state_next;
            idx      <= idx_next;
            cnt      <= cnt_next;
            result_q <= result_next;
        end
    end

    // Next-state logic: count is captured only on an accepted start, so n_ops is ignored while busy
    always_comb begin
        state_next  = state;
        idx_next    = idx;
        cnt_next    = cnt;
        result_next = result_q;
        case (state)
            IDLE: begin
                if (start) begin
                    cnt_next   = n_ops;
                    idx_next   = '0;
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                state_next = (cnt != '0) ? ADD : COMP;
            end
            ADD: begin
                if (idx == cnt - 1'b1) begin
                    state_next = COMP;
                end else begin
                    idx_next = idx + 1'b1;
                end
            end
            COMP: begin
                result_next = x;
                state_next  = x ? SMALL : LARGE;
            end
            SMALL, LARGE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Moore output decode; rd_addr only carries the index while operands are being read
    always_comb begin
        clr     = 1'b0;
        we      = 1'b0;
        s       = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        rd_addr = '0;
        case (state)
            CLEAR: begin
                clr  = 1'b1;
                busy = 1'b1;
            end
            ADD: begin
                we                  = 1'b1;
                busy                = 1'b1;
                rd_addr[CNT_W-1:0]  = idx;
            end
            COMP: begin
                s    = 1'b1;
                busy = 1'b1;
            end
            SMALL, LARGE: begin
                done = 1'b1;
                busy = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign result = result_q;

endmodule

// File: tb/tb_accum_compare_seq.sv
// tb_accum_compare_seq
// Self-checking bench: each run is predicted from the cycle-level timeline
// (clr at 1, we at 2..n+1, s at n+2, done at n+3) and the last compare value.

module tb_accum_compare_seq;

    logic       CLK = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [3:0] n_ops = 4'd0;
    logic       x = 1'b0;
    logic       clr, we, s, busy, done, result;
    logic [3:0] rd_addr;

    int   checks = 0;
    int   errors = 0;
    logic model_result = 1'b0;

    accum_compare_seq #(.CNT_W(4), .ADDR_W(4)) dut (
        .CLK     (CLK),
        .reset   (reset),
        .start   (start),
        .n_ops   (n_ops),
        .x       (x),
        .clr     (clr),
        .we      (we),
        .s       (s),
        .rd_addr (rd_addr),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    // 10-unit clock
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // One complete run from IDLE; optional noise re-pulses start and scrambles n_ops while busy
    task automatic run_check(input int n, input logic xv, input bit noise, input string tag);
        logic [5:0] got, exp;
        start = 1'b1;
        n_ops = n[3:0];
        for (int k = 1; k <= n + 4; k++) begin
            step();
            exp = {k == 1, (k >= 2) && (k <= n + 1), k == n + 2,
                   k <= n + 3, k == n + 3, (k >= n + 3) ? xv : model_result};
            got = {clr, we, s, busy, done, result};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL %s n=%0d cycle %0d {clr,we,s,busy,done,result} got %b want %b",
                         tag, n, k, got, exp);
            end
            if (exp[5] || exp[4]) begin
                checks++;
                if (rd_addr !== (exp[4] ? 4'(k - 2) : 4'd0)) begin
                    errors++;
                    $display("[TB] FAIL %s_addr n=%0d cycle %0d rd_addr got %0d want %0d",
                             tag, n, k, rd_addr, exp[4] ? k - 2 : 0);
                end
            end
            start = (noise && k < n + 4) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (noise) n_ops = 4'($urandom);
            x = (k == n + 2) ? xv : 1'($urandom_range(0, 1));
        end
        model_result = xv;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step();
        step();
        checks++;
        if ({clr, we, s, busy, done, result, rd_addr} !== 10'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got %b want 0", {clr, we, s, busy, done, result, rd_addr});
        end
        reset = 1'b1;
        step();
        checks++;
        if ({busy, done, result} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_idle {busy,done,result} got %b want 000", {busy, done, result});
        end
        model_result = 1'b0;
    endtask

    task automatic test_directed();
        run_check(3, 1'b1, 1'b0, "n3_small");
        run_check(0, 1'b0, 1'b0, "n0_large");
        run_check(15, 1'b0, 1'b0, "n15_nowrap");
        run_check(2, 1'b1, 1'b1, "ignore_start");
    endtask

    task automatic test_async_reset();
        run_check(2, 1'b1, 1'b0, "pre_reset");
        start = 1'b1;
        n_ops = 4'd5;
        step();
        start = 1'b0;
        step();
        step();
        checks++;
        if (we !== 1'b1) begin
            errors++;
            $display("[TB] FAIL areset_in_add we got %b want 1", we);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({clr, we, s, busy, done, result} !== 6'd0) begin
            errors++;
            $display("[TB] FAIL areset_drop got %b want 000000", {clr, we, s, busy, done, result});
        end
        model_result = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if ({busy, done} !== 2'b00) begin
                errors++;
                $display("[TB] FAIL areset_hold cycle %0d {busy,done} got %b want 00", k, {busy, done});
            end
        end
        reset = 1'b1;
        step();
        run_check(1, 1'($urandom_range(0, 1)), 1'b0, "after_reset");
    endtask

    task automatic test_back_to_back();
        int         ph;
        logic [2:0] exp, got;
        logic       prev;
        prev  = model_result;
        start = 1'b1;
        n_ops = 4'd1;
        x     = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            step();
            ph  = k % 5;
            exp = {ph != 0, ph == 4, (k < 4) ? prev : ((k < 9) ? 1'b1 : 1'b0)};
            got = {busy, done, result};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL back_to_back cycle %0d {busy,done,result} got %b want %b", k, got, exp);
            end
            x = (k < 5) ? 1'b1 : 1'b0;
            if (k == 9) start = 1'b0;
        end
        step();
        checks++;
        if ({busy, done, result} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL back_to_back_end {busy,done,result} got %b want 000", {busy, done, result});
        end
        model_result = 1'b0;
    endtask

    task automatic test_random_runs();
        int gap;
        for (int r = 0; r < 10; r++) begin
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                x = 1'($urandom_range(0, 1));
                step();
                checks++;
                if ({busy, done} !== 2'b00) begin
                    errors++;
                    $display("[TB] FAIL random_gap run %0d {busy,done} got %b want 00", r, {busy, done});
                end
            end
            run_check($urandom_range(0, 15), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), "random");
        end
    endtask

    // Scenario sequence followed by the summary line
    initial begin
        test_reset();
        test_directed();
        test_async_reset();
        test_back_to_back();
        test_random_runs();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
